wbu_csr_stage: RTL and testbench

Registered write-back stage with an integrated machine-mode CSR file. It sits between the LSU/WB pipeline register and the register file / commit-debug port. The block replaces purely combinational CSR write-back with architectural CSR state held inside the block, full Zicsr semantics and timer-interrupt entry. It owns trap entry and return and issues a one-cycle PC redirect to the fetch unit.

---
 rtl/wbu_csr_stage_pkg.sv | 36 +++
 rtl/wbu_csr_stage_csr_file.sv | 163 ++++++++++++++++
 rtl/wbu_csr_stage.sv | 152 +++++++++++++++
 tb/tb_wbu_csr_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_csr_stage_pkg.sv
// Shared constants for the write-back / CSR stage: CSR addresses, bit positions, CSR op codes.
// Latency: n/a (package).
// Backpressure: n/a (package).
package wbu_csr_stage_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    // Bit positions of the implemented fields
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;
    localparam int MIE_MTIE_BIT     = 7;
    localparam int MIP_MTIP_BIT     = 7;

    // func3[1:0] of a SYSTEM/CSR instruction; func3[2] only picks register vs
    // immediate source, which upstream has already folded into alures.
    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    // Interrupt code for the machine timer; the interrupt flag bit is added
    // at the top of mcause by the CSR file, so this stays width-independent.
    localparam int MCAUSE_MTI_CODE = 7;

endpackage

// File: rtl/wbu_csr_stage_csr_file.sv
// Machine-mode CSR file: read mux, Zicsr write masking, ecall/mret/timer-interrupt updates.
// Latency: combinational read of the old value; all updates land on the accept edge.
// Backpressure: none of its own; it only acts when the wrapper asserts accept.
module csr_file
    import wbu_csr_stage_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            accept,       // instruction enters the stage this edge
    input  logic            is_csr,
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic [11:0]     csr_addr,
    input  csr_op_e         csr_op,
    input  logic [4:0]      rs1_field,    // rs1 / zimm field, zero means "read only" for set/clear
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] nextpc,
    input  logic            irq_timer,
    output logic [XLEN-1:0] rdata,        // value before this instruction's write
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            trap_take,    // ecall or interrupt entry this edge
    output logic            ret_take      // mret this edge
);

    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_mtie_q,     mie_mtie_d;
    logic            mip_mtip_q;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;

    logic            wr_en;
    logic [XLEN-1:0] wr_val;
    logic            csr_we;
    logic            ecall_take;
    logic            irq_take;

    // Read mux
    always_comb begin
        rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                rdata[MSTATUS_MPIE_BIT]              = mstatus_mpie_q;
                rdata[MSTATUS_MIE_BIT]               = mstatus_mie_q;
            end
            CSR_MIE:      rdata[MIE_MTIE_BIT] = mie_mtie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MIP:      rdata[MIP_MTIP_BIT] = mip_mtip_q;
            default:      rdata = '0;
        endcase
    end

    // Zicsr write value
    always_comb begin
        wr_en  = 1'b0;
        wr_val = rdata;
        case (csr_op)
            CSR_OP_WRITE: begin
                wr_en  = 1'b1;
                wr_val = src;
            end
            CSR_OP_SET: begin
                wr_en  = (rs1_field != 5'd0);
                wr_val = rdata | src;
            end
            CSR_OP_CLEAR: begin
                wr_en  = (rs1_field != 5'd0);
                wr_val = rdata & ~src;
            end
            default: begin
                wr_en  = 1'b0;
                wr_val = rdata;
            end
        endcase
    end

    assign csr_we     = accept && is_csr && wr_en;
    assign ecall_take = accept && is_ecall;
    assign ret_take   = accept && is_mret && !is_ecall;
    // Interrupts only ride on plain instructions; otherwise they wait.
    assign irq_take   = accept && !is_csr && !is_ecall && !is_mret
                        && irq_timer && mstatus_mie_q && mie_mtie_q;
    assign trap_take  = ecall_take || irq_take;

    assign mtvec = mtvec_q;
    assign mepc  = mepc_q;

    // Next state: CSR write first, trap/return updates override
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wr_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_mtie_d = wr_val[MIE_MTIE_BIT];
                CSR_MTVEC:    mtvec_d    = wr_val;
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = wr_val;
                CSR_MCAUSE:   mcause_d   = wr_val;
                default:      ;
            endcase
        end

        if (ecall_take) begin
            mepc_d         = pc;
            mcause_d       = XLEN'(ECALL_CAUSE);
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (ret_take) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (irq_take) begin
            // The interrupted instruction retires, so resume after it.
            mepc_d         = nextpc;
            mcause_d       = {1'b1, (XLEN-1)'(MCAUSE_MTI_CODE)};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mip_mtip_q     <= 1'b0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mip_mtip_q     <= irq_timer;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

endmodule

// File: rtl/wbu_csr_stage.sv
// Registered write-back stage with machine-mode CSR file, trap entry/return and PC redirect.
// Latency: 1 cycle from accept to out_valid; redirect pulses the cycle after a trap/return accept.
// Backpressure: in_ready = !out_valid || out_ready; record held stable while stalled, no bubble on drain.
module wbu_csr_stage
    import wbu_csr_stage_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_nextpc,
    input  logic [31:0]     in_inst,
    input  logic [4:0]      in_waddr,
    input  logic            in_wen,
    input  logic            in_readflag,
    input  logic            in_csrflag,
    input  logic            in_ecallflag,
    input  logic            in_mretflag,
    input  logic [XLEN-1:0] in_alures,
    input  logic [XLEN-1:0] in_lsures,
    input  logic            irq_timer,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [4:0]      out_waddr,
    output logic            out_wen,
    output logic [XLEN-1:0] out_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    logic            accept;
    logic [XLEN-1:0] csr_rdata;
    logic [XLEN-1:0] csr_mtvec;
    logic [XLEN-1:0] csr_mepc;
    logic            trap_take;
    logic            ret_take;
    logic [XLEN-1:0] wdata_sel;

    logic            out_valid_q,      out_valid_d;
    logic [XLEN-1:0] out_pc_q,         out_pc_d;
    logic [31:0]     out_inst_q,       out_inst_d;
    logic [4:0]      out_waddr_q,      out_waddr_d;
    logic            out_wen_q,        out_wen_d;
    logic [XLEN-1:0] out_wdata_q,      out_wdata_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q,    redirect_pc_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    csr_file #(
        .XLEN        (XLEN),
        .ECALL_CAUSE (ECALL_CAUSE)
    ) u_csr_file (
        .clock     (clock),
        .reset     (reset),
        .accept    (accept),
        .is_csr    (in_csrflag),
        .is_ecall  (in_ecallflag),
        .is_mret   (in_mretflag),
        .csr_addr  (in_inst[31:20]),
        .csr_op    (csr_op_e'(in_inst[13:12])),
        .rs1_field (in_inst[19:15]),
        .src       (in_alures),
        .pc        (in_pc),
        .nextpc    (in_nextpc),
        .irq_timer (irq_timer),
        .rdata     (csr_rdata),
        .mtvec     (csr_mtvec),
        .mepc      (csr_mepc),
        .trap_take (trap_take),
        .ret_take  (ret_take)
    );

    always_comb begin
        if (in_csrflag) begin
            wdata_sel = csr_rdata;
        end else if (in_readflag) begin
            wdata_sel = in_lsures;
        end else begin
            wdata_sel = in_alures;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_waddr_d = out_waddr_q;
        out_wen_d   = out_wen_q;
        out_wdata_d = out_wdata_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            out_inst_d  = in_inst;
            out_waddr_d = in_waddr;
            out_wen_d   = in_wen;
            out_wdata_d = wdata_sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Redirect target uses the CSR values before this accept's own update.
    always_comb begin
        redirect_valid_d = trap_take || ret_take;
        redirect_pc_d    = redirect_pc_q;
        if (trap_take) begin
            redirect_pc_d = csr_mtvec;
        end else if (ret_take) begin
            redirect_pc_d = csr_mepc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_inst_q       <= '0;
            out_waddr_q      <= '0;
            out_wen_q        <= 1'b0;
            out_wdata_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_inst_q       <= out_inst_d;
            out_waddr_q      <= out_waddr_d;
            out_wen_q        <= out_wen_d;
            out_wdata_q      <= out_wdata_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;
    assign out_waddr      = out_waddr_q;
    assign out_wen        = out_wen_q;
    assign out_wdata      = out_wdata_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_wbu_csr_stage.sv
// Testbench for wbu_csr_stage: directed scenarios plus random instruction mix against a CSR model.
// Latency: checks the registered record one cycle after each accept.
// Backpressure: exercises a 3-cycle out_ready stall with a pending input.
module tb_wbu_csr_stage;

    localparam int XLEN = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc, in_nextpc;
    logic [31:0]     in_inst;
    logic [4:0]      in_waddr;
    logic            in_wen, in_readflag, in_csrflag, in_ecallflag, in_mretflag;
    logic [XLEN-1:0] in_alures, in_lsures;
    logic            irq_timer;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [4:0]      out_waddr;
    logic            out_wen;
    logic [XLEN-1:0] out_wdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    always #5 clock = ~clock;

    wbu_csr_stage #(.XLEN(XLEN), .ECALL_CAUSE(11)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_nextpc      (in_nextpc),
        .in_inst        (in_inst),
        .in_waddr       (in_waddr),
        .in_wen         (in_wen),
        .in_readflag    (in_readflag),
        .in_csrflag     (in_csrflag),
        .in_ecallflag   (in_ecallflag),
        .in_mretflag    (in_mretflag),
        .in_alures      (in_alures),
        .in_lsures      (in_lsures),
        .irq_timer      (irq_timer),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_waddr      (out_waddr),
        .out_wen        (out_wen),
        .out_wdata      (out_wdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural CSR model
    bit          m_mie, m_mpie, m_mtie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] pc_ctr;

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h304: return 64'(m_mtie) << 7;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return 64'(irq_timer) << 7;
            default: return 64'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h304: m_mtie = v[7];
            12'h305: m_mtvec = v;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v;
            12'h342: m_mcause = v;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] csr_enc(input logic [11:0] a, input logic [2:0] f3,
                                            input logic [4:0] rs1, input logic [4:0] rd);
        return {a, rs1, f3, rd, 7'h73};
    endfunction

    task automatic idle();
        in_valid = 0;
        @(posedge clock); #1;
    endtask

    task automatic set_irq(input logic v);
        irq_timer = v;
        idle();
    endtask

    // Present one instruction, wait for acceptance, then check the record
    // and redirect against the model.
    task automatic send(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] npc,
                        input logic [4:0] waddr, input logic wen, input logic rdf,
                        input logic csrf, input logic ecf, input logic mrf,
                        input logic [63:0] alu, input logic [63:0] lsu);
        int n;
        logic [63:0] exp_wdata, exp_rpc, old, nv;
        logic        exp_rv, wr;
        logic [2:0]  f3;
        in_inst = inst; in_pc = pc; in_nextpc = npc; in_waddr = waddr; in_wen = wen;
        in_readflag = rdf; in_csrflag = csrf; in_ecallflag = ecf; in_mretflag = mrf;
        in_alures = alu; in_lsures = lsu; in_valid = 1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);

        exp_rv = 0; exp_rpc = 0;
        if (csrf) begin
            old = m_read(inst[31:20]);
            exp_wdata = old;
            f3 = inst[14:12];
            wr = 0; nv = old;
            if (f3 == 3'b001 || f3 == 3'b101) begin wr = 1; nv = alu; end
            else if ((f3 == 3'b010 || f3 == 3'b110) && inst[19:15] != 0) begin wr = 1; nv = old | alu; end
            else if ((f3 == 3'b011 || f3 == 3'b111) && inst[19:15] != 0) begin wr = 1; nv = old & ~alu; end
            if (wr) m_write(inst[31:20], nv);
        end else begin
            exp_wdata = rdf ? lsu : alu;
        end
        if (ecf) begin
            exp_rv = 1; exp_rpc = m_mtvec;
            m_mepc = pc; m_mcause = 64'd11; m_mpie = m_mie; m_mie = 0;
        end else if (mrf) begin
            exp_rv = 1; exp_rpc = m_mepc;
            m_mie = m_mpie; m_mpie = 1;
        end else if (!csrf && irq_timer && m_mie && m_mtie) begin
            exp_rv = 1; exp_rpc = m_mtvec;
            m_mepc = npc; m_mcause = 64'h8000_0000_0000_0007; m_mpie = m_mie; m_mie = 0;
        end

        @(posedge clock); #1;
        in_valid = 0;
        check("out_valid", 64'(out_valid), 64'd1);
        check("out_pc", out_pc, pc);
        check("out_inst", 64'(out_inst), 64'(inst));
        check("out_waddr", 64'(out_waddr), 64'(waddr));
        check("out_wen", 64'(out_wen), 64'(wen));
        check("out_wdata", out_wdata, exp_wdata);
        check("redirect_valid", 64'(redirect_valid), 64'(exp_rv));
        if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
        pc_ctr = pc_ctr + 4;
    endtask

    task automatic do_csr(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] rs1,
                          input logic [4:0] rd, input logic [63:0] src);
        send(csr_enc(a, f3, rs1, rd), pc_ctr, pc_ctr + 4, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
             src, {$urandom, $urandom});
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic rdf, input logic [63:0] alu,
                          input logic [63:0] lsu);
        send(32'h0000_0033 | (32'(rd) << 7), pc_ctr, pc_ctr + 4, rd, 1'b1, rdf, 1'b0, 1'b0, 1'b0,
             alu, lsu);
    endtask

    task automatic do_ecall(input logic [63:0] pc);
        send(32'h0000_0073, pc, pc + 4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic do_mret();
        send(32'h3020_0073, pc_ctr, pc_ctr + 4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [11:0] addr_tab [8];

    initial begin
        addr_tab = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h7C0};
        reset = 1; in_valid = 0; out_ready = 1; irq_timer = 0;
        in_pc = 0; in_nextpc = 0; in_inst = 0; in_waddr = 0; in_wen = 0;
        in_readflag = 0; in_csrflag = 0; in_ecallflag = 0; in_mretflag = 0;
        in_alures = 0; in_lsures = 0;
        pc_ctr = 64'h8000_0000;
        m_reset();
        repeat (3) @(posedge clock);
        #1 reset = 0;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_wdata", out_wdata, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // csrrs x5, mstatus, x0
        do_csr(12'h300, 3'b010, 5'd0, 5'd5, 64'd0);
        check("plan_mstatus_rd", out_wdata, 64'h1800);
        check("plan_mstatus_waddr", 64'(out_waddr), 64'd5);
        do_csr(12'h300, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_mstatus_unchanged", out_wdata, 64'h1800);

        // mtvec then ecall
        do_csr(12'h305, 3'b001, 5'd1, 5'd0, 64'h8000_0100);
        do_ecall(64'h8000_0040);
        check("plan_ecall_rv", 64'(redirect_valid), 64'd1);
        check("plan_ecall_rpc", redirect_pc, 64'h8000_0100);
        idle();
        check("plan_ecall_pulse_end", 64'(redirect_valid), 64'd0);
        do_csr(12'h341, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_ecall_mepc", out_wdata, 64'h8000_0040);
        do_csr(12'h342, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_ecall_mcause", out_wdata, 64'd11);
        do_csr(12'h300, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_ecall_mie", out_wdata, 64'h1800);

        // Back-to-back ecalls: one pulse each
        do_ecall(64'h8000_0080);
        check("b2b_ecall1_rv", 64'(redirect_valid), 64'd1);
        do_ecall(64'h8000_0084);
        check("b2b_ecall2_rv", 64'(redirect_valid), 64'd1);
        check("b2b_ecall2_rpc", redirect_pc, 64'h8000_0100);

        // Timer interrupt on a plain add
        do_csr(12'h300, 3'b010, 5'd1, 5'd0, 64'h8);
        do_csr(12'h304, 3'b010, 5'd1, 5'd0, 64'h80);
        set_irq(1);
        do_csr(12'h344, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_mip_mtip", out_wdata, 64'h80);
        check("plan_irq_deferred_on_csr", 64'(redirect_valid), 64'd0);
        pc_ctr = 64'h8000_0200;
        do_alu(5'd7, 1'b0, 64'h1234, 64'h0);
        check("plan_irq_retire", out_wdata, 64'h1234);
        check("plan_irq_rv", 64'(redirect_valid), 64'd1);
        check("plan_irq_rpc", redirect_pc, 64'h8000_0100);
        set_irq(0);
        do_csr(12'h341, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_irq_mepc", out_wdata, 64'h8000_0204);
        do_csr(12'h342, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_irq_mcause", out_wdata, 64'h8000_0000_0000_0007);
        do_csr(12'h300, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_irq_mstatus", out_wdata, 64'h1880);

        // mret
        do_mret();
        check("plan_mret_rpc", redirect_pc, 64'h8000_0204);
        do_csr(12'h300, 3'b010, 5'd0, 5'd1, 64'd0);
        check("plan_mret_mstatus", out_wdata, 64'h1888);

        // Stall: hold out_ready low with a pending input
        do_alu(5'd3, 1'b0, 64'hAAAA, 64'h0);
        out_ready = 0;
        in_inst = 32'h0000_0233; in_pc = 64'h9000_0000; in_nextpc = 64'h9000_0004;
        in_waddr = 5'd4; in_wen = 1; in_readflag = 1; in_csrflag = 0;
        in_ecallflag = 0; in_mretflag = 0; in_alures = 64'h1; in_lsures = 64'hBEEF;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_wdata", out_wdata, 64'hAAAA);
            check("stall_out_waddr", 64'(out_waddr), 64'd3);
        end
        out_ready = 1;
        #1 check("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        in_valid = 0;
        check("release_out_valid", 64'(out_valid), 64'd1);
        check("release_out_pc", out_pc, 64'h9000_0000);
        check("release_out_wdata", out_wdata, 64'hBEEF);

        // csrrc with zero rs1, and an unmapped address
        do_csr(12'h340, 3'b001, 5'd1, 5'd0, 64'h55AA);
        do_csr(12'h340, 3'b011, 5'd0, 5'd2, 64'hFF);
        check("plan_csrrc_x0_old", out_wdata, 64'h55AA);
        do_csr(12'h340, 3'b010, 5'd0, 5'd2, 64'd0);
        check("plan_csrrc_x0_nowrite", out_wdata, 64'h55AA);
        do_csr(12'h7C0, 3'b001, 5'd2, 5'd2, 64'h1234);
        check("plan_unmapped_wdata", out_wdata, 64'd0);
        do_csr(12'h7C0, 3'b010, 5'd0, 5'd2, 64'd0);
        check("plan_unmapped_read", out_wdata, 64'd0);

        // Random instruction mix against the model
        for (int it = 0; it < 300; it++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k <= 2) begin
                logic [63:0] src;
                logic [4:0]  rs1;
                src = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255));
                rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                do_csr(addr_tab[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), rs1,
                       5'($urandom_range(0, 31)), src);
            end else if (k == 3 || k == 4) begin
                do_alu(5'($urandom_range(0, 31)), k == 4, {$urandom, $urandom}, {$urandom, $urandom});
            end else if (k == 5) begin
                do_ecall(pc_ctr);
            end else if (k == 6) begin
                do_mret();
            end else if (k == 7) begin
                set_irq(1'($urandom_range(0, 1)));
            end else begin
                idle();
                check("rand_idle_no_redirect", 64'(redirect_valid), 64'd0);
            end
        end

        // Reset while a record is held and an ecall is being accepted
        set_irq(0);
        do_alu(5'd9, 1'b0, 64'h77, 64'h0);
        in_inst = 32'h0000_0073; in_pc = 64'h8000_0500; in_nextpc = 64'h8000_0504;
        in_waddr = 0; in_wen = 0; in_readflag = 0; in_csrflag = 0;
        in_ecallflag = 1; in_mretflag = 0; in_valid = 1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0; in_valid = 0; in_ecallflag = 0;
        m_reset();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_pc", out_pc, 64'd0);
        check("midrst_redirect_valid", 64'(redirect_valid), 64'd0);
        idle();
        check("midrst_redirect_later", 64'(redirect_valid), 64'd0);
        do_csr(12'h300, 3'b010, 5'd0, 5'd1, 64'd0);
        check("midrst_mstatus", out_wdata, 64'h1800);
        do_csr(12'h341, 3'b010, 5'd0, 5'd1, 64'd0);
        check("midrst_mepc", out_wdata, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
